ov7670_sccb_config: RTL
=======================

# ov7670_sccb_config

Power-up configuration sequencer for the OV7670 camera. It walks an external register table and issues one SCCB 3-phase write (device ID, register address, data) per entry on SCL/SDA. It sits beside the camera capture path in the top level and drives the camera's SCL/SDA pins. It runs automatically after reset and again on a `start` pulse, so capture modes can be reloaded without a full reset.

## Interface
- `DIV`, 250: clk cycles per SCL quarter-period (100 MHz / 250 / 4 = 100 kHz SCL); legal range ≥ 2
- `PWR_DELAY`, 1_000_000: clk cycles waited after reset release before the first transaction
- `DEV_ID`, 8'h42: SCCB write ID sent as byte 0
- `ADDR_W`, 8: table address width; max 2^ADDR_W entries
- `clk`  in  1  system clock; the block's only clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; restarts the table walk from entry 0; ignored while `busy`
- `rom_addr`  out  ADDR_W  table index being fetched
- `rom_data`  in  16  table entry; [15:8] register address, [7:0] data; 16'hFFFF = end of table
- `SCL`  out  1  SCCB clock
- `SDA`  out  1  SCCB data, push-pull; driven 1 during ack bits
- `busy`  out  1  high from the start of the power-up wait or a `start` until DONE
- `done`  out  1  high in DONE; cleared on `start` or reset

## Operation
- Reset values: SCL=1, SDA=1, busy=0, done=0, rom_addr=0, state=WAIT_PWR.
- States: WAIT_PWR → FETCH → (START → BITS → STOP → GAP → FETCH)* → DONE.
- WAIT_PWR: busy=1. Counts PWR_DELAY cycles, then goes to FETCH with rom_addr=0.
- FETCH: 2 cycles. rom_data is sampled at the end of the second cycle, so a synchronous ROM with 1-cycle latency is supported.
  - Entry 16'hFFFF → DONE.
  - Otherwise the 27-bit shift word {DEV_ID,1, addr,1, data,1} is loaded and the state goes to START.
- START: quarter 0 SCL=1 SDA=1; quarter 1 SCL=1 SDA=0.
- BITS: 27 bits, MSB first. Each bit is 4 quarters:
  - SDA is updated at the start of q0.
  - SCL is 0 in q0, 1 in q1, 1 in q2, 0 in q3.
  - Ack positions (bits 9, 18, 27) drive SDA=1; the slave ack is not checked.
- STOP: q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2 SCL=1 SDA=1.
- GAP: 4 quarters with SCL=1 SDA=1. Then rom_addr increments and the state goes to FETCH.
- rom_addr wrap: if rom_addr=2^ADDR_W−1 completes without a terminator, the next state is DONE (no wrap to 0).
- DONE: busy=0, done=1, SCL=1, SDA=1. A `start` pulse clears done, sets busy, rom_addr=0, and goes to FETCH (no power-up wait).
- `start` while busy=1 is ignored. `start` coincident with the last GAP cycle is also ignored.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). After release, the full PWR_DELAY wait repeats.

## Timing
- Quarter tick: a free-running divider counting 0..DIV−1, cleared on every state entry.
- Outputs are registered and change one clk after the tick.
- Transaction length: (2 + 108 + 3 + 4) × DIV = 117·DIV cycles, plus 2 FETCH cycles.
- First SDA fall occurs PWR_DELAY + 2 + DIV cycles after reset release, ±1 cycle.
- Terminator path: 2 FETCH cycles, then done=1 on the following cycle.
- SDA changes only while SCL=0, except during START and STOP.

## Test plan
- DIV=2, PWR_DELAY=10. Table {16'h1280, 16'hFFFF}, reset released → one START, then SDA bit sequence 0100_0010_1 0001_0010_1 1000_0000_1 sampled on SCL rising edges, then STOP. done=1 after 2+117·2+2+1 cycles past the wait; rom_addr ends at 1.
- Table of 3 writes then FFFF → exactly 3 START/STOP pairs, each separated by ≥4 quarters of SCL=SDA=1. busy falls when done rises.
- Entry 0 = FFFF → no SCL edges at all. done=1 three cycles after WAIT_PWR ends.
- From DONE: `start` pulse → done=0 and busy=1 next cycle, rom_addr=0, transactions reissued. A second `start` mid-run → no effect on the sequence.
- Reset asserted during the BITS of transaction 2 → SCL=SDA=1 and busy=0 in the same cycle. After release, the sequence restarts from entry 0 after PWR_DELAY.
- Monitor for the whole run: SDA never toggles while SCL=1, except at START/STOP. rom_data changes outside FETCH have no effect.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up register loader: walks an external table and issues one
// SCCB 3-phase write (ID, register, data) per entry until 16'hFFFF is read.
module ov7670_sccb_config #(
    parameter int          DIV       = 250,
    parameter int          PWR_DELAY = 1_000_000,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              SCL,
    output logic              SDA,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = $clog2(DIV);
    localparam int PWR_W = $clog2(PWR_DELAY + 1);

    typedef enum logic [2:0] {
        WAIT_PWR,
        FETCH,
        START,
        BITS,
        STOP,
        GAP,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt;
    logic [PWR_W-1:0]    pwr_cnt, pwr_cnt_n;
    logic [1:0]          qtr, qtr_n;
    logic [4:0]          bit_cnt, bit_cnt_n;
    logic [26:0]         shreg, shreg_n;
    logic [ADDR_W-1:0]   rom_addr_n;
    logic                scl_n, sda_n;
    logic                tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Control state and registered pin values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_PWR;
            div_cnt  <= '0;
            pwr_cnt  <= '0;
            qtr      <= '0;
            rom_addr <= '0;
            SCL      <= 1'b1;
            SDA      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            // Quarter divider restarts on every state entry
            if (state_n != state || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            pwr_cnt  <= pwr_cnt_n;
            qtr      <= qtr_n;
            rom_addr <= rom_addr_n;
            SCL      <= scl_n;
            SDA      <= sda_n;
            busy     <= (state_n != DONE);
            done     <= (state_n == DONE);
        end
    end

    // Shift datapath carries no reset
    always_ff @(posedge clk) begin
        shreg   <= shreg_n;
        bit_cnt <= bit_cnt_n;
    end

    always_comb begin
        state_n    = state;
        pwr_cnt_n  = pwr_cnt;
        qtr_n      = qtr;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rom_addr_n = rom_addr;
        scl_n      = SCL;
        sda_n      = SDA;

        case (state)
            WAIT_PWR: begin
                if (pwr_cnt == PWR_W'(PWR_DELAY - 1)) begin
                    pwr_cnt_n  = '0;
                    rom_addr_n = '0;
                    state_n    = FETCH;
                end else begin
                    pwr_cnt_n = pwr_cnt + 1'b1;
                end
            end
            // Second FETCH cycle leaves room for a registered ROM
            FETCH: begin
                if (div_cnt == DIV_W'(1)) begin
                    if (rom_data == 16'hFFFF) begin
                        state_n = DONE;
                    end else begin
                        shreg_n = {DEV_ID, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
                        state_n = START;
                        qtr_n   = 2'd0;
                        scl_n   = 1'b1;
                        sda_n   = 1'b1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    if (qtr == 2'd0) begin
                        qtr_n = 2'd1;
                        sda_n = 1'b0;
                    end else begin
                        state_n   = BITS;
                        qtr_n     = 2'd0;
                        bit_cnt_n = 5'd0;
                        scl_n     = 1'b0;
                        sda_n     = shreg[26];
                    end
                end
            end
            BITS: begin
                if (tick) begin
                    case (qtr)
                        2'd0: begin
                            scl_n = 1'b1;
                            qtr_n = 2'd1;
                        end
                        2'd1: qtr_n = 2'd2;
                        2'd2: begin
                            scl_n = 1'b0;
                            qtr_n = 2'd3;
                        end
                        default: begin
                            qtr_n = 2'd0;
                            if (bit_cnt == 5'd26) begin
                                state_n = STOP;
                                sda_n   = 1'b0;
                            end else begin
                                bit_cnt_n = bit_cnt + 1'b1;
                                shreg_n   = {shreg[25:0], 1'b0};
                                sda_n     = shreg[25];
                            end
                        end
                    endcase
                end
            end
            STOP: begin
                if (tick) begin
                    if (qtr == 2'd0) begin
                        scl_n = 1'b1;
                        qtr_n = 2'd1;
                    end else if (qtr == 2'd1) begin
                        sda_n = 1'b1;
                        qtr_n = 2'd2;
                    end else begin
                        state_n = GAP;
                        qtr_n   = 2'd0;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (qtr == 2'd3) begin
                        // Last table slot ends the walk instead of wrapping to 0
                        if (rom_addr == {ADDR_W{1'b1}}) begin
                            state_n = DONE;
                        end else begin
                            rom_addr_n = rom_addr + 1'b1;
                            state_n    = FETCH;
                        end
                    end else begin
                        qtr_n = qtr + 1'b1;
                    end
                end
            end
            DONE: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
                if (start) begin
                    rom_addr_n = '0;
                    state_n    = FETCH;
                end
            end
            default: state_n = WAIT_PWR;
        endcase
    end

endmodule
